ram_io_responder: RTL and testbench

- Responder (target) end of the byte-serial RAM bus that mem_ctrl drives.
- Services one byte per cycle: block-RAM reads/writes, plus memory-mapped IO for the region addr[17:16]==2'b11.
- IO writes go into a TX FIFO drained by the UART/host side. IO reads pop an RX byte or return status.
- Generates io_buffer_full, which mem_ctrl uses to stall IO writes.

---
 rtl/ram_io_responder_pkg.sv | 30 +++
 rtl/ram_io_responder_io_tx_fifo.sv | 52 +++++
 rtl/ram_io_responder.sv | 71 +++++++
 tb/tb_ram_io_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ram_io_responder_pkg.sv
// ram_io_responder_pkg: bus encodings, IO map constants and access decode for the RAM/IO responder
package ram_io_responder_pkg;

    localparam int ADDR_LEN = 32;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] IO_SEL   = 2'b11;
    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_STAT = 3'd4;

    typedef enum logic [2:0] {
        ACC_RAM_RD,
        ACC_RAM_WR,
        ACC_IO_DATA_RD,
        ACC_IO_DATA_WR,
        ACC_IO_STAT_RD,
        ACC_IO_HALT_WR,
        ACC_IO_NONE
    } acc_e;

    function automatic acc_e decode(input logic [ADDR_LEN-1:0] addr, input logic rw);
        if (addr[17:16] != IO_SEL) return rw == RW_WRITE ? ACC_RAM_WR : ACC_RAM_RD;
        if (addr[2:0] == OFF_DATA) return rw == RW_WRITE ? ACC_IO_DATA_WR : ACC_IO_DATA_RD;
        if (addr[2:0] == OFF_STAT) return rw == RW_WRITE ? ACC_IO_HALT_WR : ACC_IO_STAT_RD;
        return ACC_IO_NONE;
    endfunction

endpackage

// File: rtl/ram_io_responder_io_tx_fifo.sv
// io_tx_fifo: byte FIFO with count, registered near-full flag and sticky overflow
module io_tx_fifo #(
    parameter int DEPTH  = 8,
    parameter int MARGIN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] wdata,
    input  logic       ready,
    output logic [7:0] rdata,
    output logic       valid,
    output logic       near_full,
    output logic       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
    localparam logic [PW:0] NEAR_CNT = (PW+1)'(DEPTH - MARGIN);

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic [PW:0]   count, next_count;
    logic          pop, accept;

    assign valid      = count != '0;
    assign rdata      = buf_q[rptr];
    assign pop        = valid && ready;
    assign accept     = push && (count != FULL_CNT || pop);
    assign next_count = count + (PW+1)'(accept) - (PW+1)'(pop);

    // storage: contents need no reset, pointers define what is live
    always_ff @(posedge clk)
        if (accept) buf_q[wptr] <= wdata;

    // pointers, occupancy, near-full look-ahead and sticky overflow
    always_ff @(posedge clk)
        if (rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            near_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wptr      <= wptr + PW'(accept);
            rptr      <= rptr + PW'(pop);
            count     <= next_count;
            near_full <= next_count >= NEAR_CNT;
            overflow  <= overflow | (push && !accept);
        end

endmodule

// File: rtl/ram_io_responder.sv
// ram_io_responder: byte-serial RAM bus target with block RAM and memory-mapped TX/RX/halt IO
module ram_io_responder
    import ram_io_responder_pkg::*;
#(
    parameter int RAM_ADDR_W  = 17,
    parameter int FIFO_DEPTH  = 8,
    parameter int FULL_MARGIN = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] ram_addr,
    input  logic                ram_rw,
    input  logic [7:0]          ram_wdata,
    output logic [7:0]          ram_rdata,
    output logic                io_buffer_full,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                tx_overflow,
    output logic                sim_done
);

    logic [7:0]            mem [2**RAM_ADDR_W];
    logic [RAM_ADDR_W-1:0] ram_idx;
    acc_e                  acc;
    logic [ADDR_LEN-1:0]   last_rd_addr;
    logic                  last_rd_vld;
    logic                  rd_new;

    assign ram_idx  = ram_addr[RAM_ADDR_W-1:0];
    assign acc      = decode(ram_addr, ram_rw);
    assign rd_new   = !(last_rd_vld && last_rd_addr == ram_addr);
    assign rx_ready = !rst && acc == ACC_IO_DATA_RD && rd_new && rx_valid;

    io_tx_fifo #(.DEPTH(FIFO_DEPTH), .MARGIN(FULL_MARGIN)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (acc == ACC_IO_DATA_WR),
        .wdata    (ram_wdata),
        .ready    (tx_ready),
        .rdata    (tx_data),
        .valid    (tx_valid),
        .near_full(io_buffer_full),
        .overflow (tx_overflow)
    );

    // RAM writes; address 0 is the sink for mem_ctrl's suppressed IO writes
    always_ff @(posedge clk)
        if (!rst && acc == ACC_RAM_WR && ram_idx != '0) mem[ram_idx] <= ram_wdata;

    // read data mux, halt flag and repeated-IO-read tracking
    always_ff @(posedge clk)
        if (rst) begin
            ram_rdata    <= 8'h00;
            sim_done     <= 1'b0;
            last_rd_vld  <= 1'b0;
            last_rd_addr <= '0;
        end else begin
            ram_rdata    <= acc == ACC_RAM_RD     ? mem[ram_idx] :
                            acc == ACC_IO_DATA_RD ? (rd_new ? (rx_valid ? rx_data : 8'h00) : ram_rdata) :
                            acc == ACC_IO_STAT_RD ? {5'b0, sim_done, tx_overflow, ~tx_valid} :
                            acc == ACC_IO_NONE && ram_rw == RW_READ ? 8'h00 : ram_rdata;
            sim_done     <= sim_done | (acc == ACC_IO_HALT_WR);
            last_rd_vld  <= acc == ACC_IO_DATA_RD;
            last_rd_addr <= ram_addr;
        end

endmodule

// File: tb/tb_ram_io_responder.sv
// tb_ram_io_responder: directed and randomized checks against a queue/array reference model
module tb_ram_io_responder;

    localparam int DEPTH  = 8;
    localparam int MARGIN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ram_addr;
    logic        ram_rw;
    logic [7:0]  ram_wdata, ram_rdata, tx_data, rx_data;
    logic        io_buffer_full, tx_valid, tx_ready, rx_valid, rx_ready, tx_overflow, sim_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_io_responder #(.RAM_ADDR_W(17), .FIFO_DEPTH(DEPTH), .FULL_MARGIN(MARGIN)) dut (
        .clk           (clk),
        .rst           (rst),
        .ram_addr      (ram_addr),
        .ram_rw        (ram_rw),
        .ram_wdata     (ram_wdata),
        .ram_rdata     (ram_rdata),
        .io_buffer_full(io_buffer_full),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .tx_overflow   (tx_overflow),
        .sim_done      (sim_done)
    );

    logic [7:0]  ram_m [int];
    logic [7:0]  txq [$];
    logic        ovf_m = 1'b0, done_m = 1'b0, rd_known = 1'b1, last_ok = 1'b0;
    logic [7:0]  rd_m = 8'h00;
    logic [31:0] last_a = 32'h0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // one bus cycle: drive at negedge, check rx_ready before the edge, check state at next negedge
    task automatic step(input string tag, input logic [31:0] a, input logic rw, input logic [7:0] wd);
        logic       io, rxp;
        logic [2:0] off;
        logic [7:0] stat_m;
        int         idx;
        ram_addr  = a;
        ram_rw    = rw;
        ram_wdata = wd;
        #1;
        io     = a[17:16] == 2'b11;
        off    = a[2:0];
        idx    = int'(a[16:0]);
        rxp    = !rst && io && off == 3'd0 && !rw && rx_valid && !(last_ok && last_a == a);
        check({tag, "/rx_ready"}, 32'(rx_ready), 32'(rxp));
        stat_m = {5'b0, done_m, ovf_m, txq.size() == 0};
        if (rst) begin
            txq.delete();
            ovf_m = 0; done_m = 0; rd_m = 0; rd_known = 1; last_ok = 0;
        end else begin
            if (txq.size() > 0 && tx_ready) void'(txq.pop_front());
            if (!io) begin
                if (rw) begin
                    if (idx != 0) ram_m[idx] = wd;
                end else begin
                    rd_known = ram_m.exists(idx);
                    rd_m     = rd_known ? ram_m[idx] : 8'h00;
                end
            end else if (rw) begin
                if (off == 3'd0) begin
                    if (txq.size() < DEPTH) txq.push_back(wd);
                    else ovf_m = 1;
                end else if (off == 3'd4) done_m = 1;
            end else begin
                if (off == 3'd0) begin
                    if (!(last_ok && last_a == a)) begin rd_m = rx_valid ? rx_data : 8'h00; rd_known = 1; end
                end else begin
                    rd_m = off == 3'd4 ? stat_m : 8'h00;
                    rd_known = 1;
                end
            end
            last_ok = io && off == 3'd0 && !rw;
            last_a  = a;
        end
        @(negedge clk);
        if (rd_known) check({tag, "/ram_rdata"}, 32'(ram_rdata), 32'(rd_m));
        check({tag, "/tx_valid"}, 32'(tx_valid), 32'(txq.size() != 0));
        if (txq.size() != 0) check({tag, "/tx_data"}, 32'(tx_data), 32'(txq[0]));
        check({tag, "/io_buffer_full"}, 32'(io_buffer_full), 32'(txq.size() >= DEPTH - MARGIN));
        check({tag, "/tx_overflow"}, 32'(tx_overflow), 32'(ovf_m));
        check({tag, "/sim_done"}, 32'(sim_done), 32'(done_m));
    endtask

    initial begin
        logic [7:0] pat [4];
        int         pulses;
        logic [31:0] a;
        pat = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        rst = 1; tx_ready = 0; rx_valid = 0; rx_data = 0;
        ram_addr = 0; ram_rw = 0; ram_wdata = 0;
        @(negedge clk);
        step("reset", 32'h1, 0, 8'h00);
        check("reset/ram_rdata0", 32'(ram_rdata), 32'h0);
        rst = 0;

        for (int i = 0; i < 4; i++) step("ram_wr", 32'h10 + i, 1, pat[i]);
        for (int i = 0; i < 4; i++) begin
            step("ram_rd", 32'h10 + i, 0, 8'h00);
            check("ram_rd_pattern", 32'(ram_rdata), 32'(pat[i]));
        end
        step("ram_rd_hold_on_wr", 32'h20, 1, 8'h77);
        check("rdata_hold_on_wr", 32'(ram_rdata), 32'hDD);

        step("zero_wr", 32'h0, 1, 8'h55);
        step("zero_rd", 32'h0, 0, 8'h00);
        checks++;
        assert (ram_rdata !== 8'h55) else begin
            errors++;
            $error("FAIL addr0_discard: observed %0h expected not 55", ram_rdata);
        end

        for (int i = 0; i < 6; i++) step("push6", 32'h30000, 1, 8'(8'h60 + i));
        check("near_full_after6", 32'(io_buffer_full), 32'h1);
        for (int i = 0; i < 3; i++) step("push_over", 32'h30000, 1, 8'(8'h70 + i));
        check("overflow_set", 32'(tx_overflow), 32'h1);
        tx_ready = 1;
        for (int i = 0; i < 9; i++) step("drain", 32'h100, 0, 8'h00);
        check("drained_empty", 32'(tx_valid), 32'h0);

        rst = 1; step("reset2", 32'h100, 0, 8'h00); rst = 0;
        tx_ready = 0;
        for (int i = 0; i < 8; i++) step("fill8", 32'h30000, 1, 8'(8'h80 + i));
        tx_ready = 1;
        for (int i = 0; i < 5; i++) step("push_pop_full", 32'h30000, 1, 8'(8'h90 + i));
        check("no_overflow_full_pushpop", 32'(tx_overflow), 32'h0);
        for (int i = 0; i < 9; i++) step("drain2", 32'h100, 0, 8'h00);

        rx_valid = 1; rx_data = 8'h41; pulses = 0;
        for (int i = 0; i < 4; i++) begin
            ram_addr = 32'h30000; ram_rw = 0; #1;
            pulses += int'(rx_ready);
            step("rx_held", 32'h30000, 0, 8'h00);
            check("rx_byte", 32'(ram_rdata), 32'h41);
        end
        check("rx_single_pulse", 32'(pulses), 32'd1);
        rx_valid = 0;
        step("rx_gap", 32'h100, 0, 8'h00);
        step("rx_empty", 32'h30000, 0, 8'h00);
        check("rx_empty_zero", 32'(ram_rdata), 32'h0);
        step("io_other_rd", 32'h30002, 0, 8'h00);

        step("halt", 32'h30004, 1, 8'h3C);
        check("sim_done_set", 32'(sim_done), 32'h1);
        step("status", 32'h30004, 0, 8'h00);
        check("status_bit2", 32'(ram_rdata[2]), 32'h1);
        step("push_pre_reset", 32'h30000, 1, 8'hE1);
        rx_valid = 1; rx_data = 8'h99; tx_ready = 0;
        rst = 1; step("reset_mid", 32'h30000, 0, 8'h00); rst = 0;
        check("reset_sim_done", 32'(sim_done), 32'h0);
        check("reset_fifo_empty", 32'(tx_valid), 32'h0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 5))
                0, 1: a = 32'h200 + 32'($urandom_range(0, 15));
                2:    a = 32'h0;
                3:    a = 32'h30000;
                4:    a = 32'h30004;
                default: a = 32'h30000 + 32'($urandom_range(0, 7));
            endcase
            tx_ready = 1'($urandom);
            rx_valid = 1'($urandom);
            rx_data  = 8'($urandom);
            rst      = $urandom_range(0, 99) == 0;
            step("rand", a, 1'($urandom), 8'($urandom));
        end
        rst = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
